alu_regfile: RTL and testbench

ALU_REGFILE -- requirements
Module: alu_regfile

---
 rtl/alu_regfile.sv | 45 ++++
 tb/tb_alu_regfile.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_regfile.sv
// alu_regfile: 16-entry register file plus combinational shift/add/sub/and ALU; define ALU_REGFILE_BYPASS_EN for write-through reads
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addrA,
   input  logic [ADDR_W-1:0] addrB,
   input  logic [ADDR_W-1:0] addrW,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              WE,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   input  logic [3:0]        shift,
   output logic [DATA_W-1:0] out,
   output logic              zero,
   output logic              negative
);
   logic [DATA_W-1:0] regs [2**ADDR_W];
   logic [DATA_W-1:0] bs;
   always_ff @(posedge clk)
      if (reset) for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      else if (WE) regs[addrW] <= dataIn;
`ifdef ALU_REGFILE_BYPASS_EN
   logic wrLive;
   assign wrLive = WE && !reset;
   assign A = (wrLive && addrA == addrW) ? dataIn : regs[addrA];
   assign B = (wrLive && addrB == addrW) ? dataIn : regs[addrB];
`else
   assign A = regs[addrA];
   assign B = regs[addrB];
`endif
   always_comb begin
      bs  = b << shift;
      out = op == 2'b00 ? a + bs :
            op == 2'b01 ? a - bs :
            op == 2'b10 ? a & bs : a >> shift;
   end
   assign zero     = out == '0;
   assign negative = out[DATA_W-1];
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed self-checking bench for alu_regfile
module tb_alu_regfile;
   logic        clk = 0;
   logic        reset = 0;
   logic [3:0]  addrA = 0, addrB = 0, addrW = 0;
   logic [31:0] dataIn = 0;
   logic        WE = 0;
   logic [31:0] A, B;
   logic [31:0] a = 0, b = 0;
   logic [1:0]  op = 0;
   logic [3:0]  shift = 0;
   logic [31:0] out;
   logic        zero, negative;
   int nChecks = 0;
   int nFails = 0;

   alu_regfile dut (
      .clk(clk), .reset(reset), .addrA(addrA), .addrB(addrB), .addrW(addrW),
      .dataIn(dataIn), .WE(WE), .A(A), .B(B), .a(a), .b(b), .op(op),
      .shift(shift), .out(out), .zero(zero), .negative(negative)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic writeReg(input logic [3:0] adr, input logic [31:0] val);
      addrW = adr; dataIn = val; WE = 1;
      tick();
      WE = 0;
   endtask

   task automatic aluCheck(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] s, input logic [31:0] exp);
      op = o; a = x; b = y; shift = s;
      #1;
      check({tag, "_out"}, out, exp);
      check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 0});
      check({tag, "_neg"}, {31'b0, negative}, {31'b0, exp[31]});
   endtask

   initial begin
      reset = 1;
      tick();
      reset = 0;
      for (int i = 0; i < 16; i++) begin
         addrA = 4'(i); addrB = 4'(15 - i);
         #1;
         check("rst_A", A, 0);
         check("rst_B", B, 0);
      end
      // Reset must win over a simultaneous write
      writeReg(5, 32'hDEADBEEF);
      addrA = 5; #1;
      check("r5_written", A, 32'hDEADBEEF);
      addrW = 5; dataIn = 32'hDEADBEEF; WE = 1; reset = 1;
      tick();
      WE = 0; reset = 0;
      check("r5_reset_prio", A, 0);

      writeReg(3, 32'h12345678);
      writeReg(15, 32'hFFFFFFFF);
      addrA = 3; addrB = 15; #1;
      check("r3_A", A, 32'h12345678);
      check("r15_B", B, 32'hFFFFFFFF);
      for (int i = 0; i < 15; i++) if (i != 3) begin
         addrA = 4'(i); #1;
         check("untouched", A, 0);
      end
      addrW = 3; dataIn = 32'h0BADF00D; WE = 0;
      tick();
      addrA = 3; #1;
      check("we0_hold", A, 32'h12345678);

      writeReg(7, 32'h11);
      addrA = 7; addrB = 7; addrW = 7; dataIn = 32'hA5; WE = 1;
      #1;
`ifdef ALU_REGFILE_BYPASS_EN
      check("pre_edge_A", A, 32'hA5);
      check("pre_edge_B", B, 32'hA5);
`else
      check("pre_edge_A", A, 32'h11);
      check("pre_edge_B", B, 32'h11);
`endif
      tick();
      WE = 0; #1;
      check("post_edge_A", A, 32'hA5);
      check("post_edge_B", B, 32'hA5);

      aluCheck("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h1, 4'd0, 32'h0);
      aluCheck("add_sh4", 2'b00, 32'h1, 32'h1, 4'd4, 32'h11);
      aluCheck("sub_wrap", 2'b01, 32'h0, 32'h1, 4'd0, 32'hFFFFFFFF);
      aluCheck("and_sh4", 2'b10, 32'hF0F0F0F0, 32'hFF, 4'd4, 32'hF0);
      aluCheck("srl_15", 2'b11, 32'h80000000, 32'hDEADBEEF, 4'd15, 32'h00010000);
      aluCheck("add_trunc", 2'b00, 32'h0, 32'h80000001, 4'd15, 32'h00008000);
      aluCheck("sub_sh8", 2'b01, 32'h100, 32'h1, 4'd8, 32'h0);
      aluCheck("srl_0", 2'b11, 32'hFFFFFFFF, 32'h0, 4'd0, 32'hFFFFFFFF);
      aluCheck("and_sh15", 2'b10, 32'hFFFFFFFF, 32'hFFFF, 4'd15, 32'h7FFF8000);
      reset = 1;
      aluCheck("alu_in_reset", 2'b01, 32'h10, 32'h1, 4'd1, 32'hE);
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
